// File: rtl/dsp_chain_pkg.sv
// Shared constants and types for the fp16 sum-of-products chain and its result drain.
package dsp_chain_pkg;

    localparam int DSP_RESULT_W              = 32;
    localparam int FP16_SOP2_CHAIN4_LATENCY  = 4;

    typedef logic [DSP_RESULT_W-1:0] dsp_result_t;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dsp_result_fifo.sv
// Result buffer for the chain drain: synchronous FIFO with first-word fall-through head.
module dsp_result_fifo
    import dsp_chain_pkg::*;
#(
    parameter int DATA_W = DSP_RESULT_W,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = occ_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/dsp_chain_result_drain.sv
// Drain for the last DSP chain stage: tracks issues through the fixed latency, captures
// results into a FIFO and throttles issue with credits so no result is ever lost.
module dsp_chain_result_drain
    import dsp_chain_pkg::*;
#(
    parameter int DATA_W              = DSP_RESULT_W,
    parameter int LATENCY             = FP16_SOP2_CHAIN4_LATENCY,
    parameter int DEPTH               = 8,
    parameter bit CREDIT_CHECK_BYPASS = 1'b0,
    localparam int CNT_W              = occ_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [DATA_W-1:0] chain_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  inflight,
    output logic              overflow_err
);

    logic [LATENCY-1:0] dly_q, dly_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic               issue_ready_q, issue_ready_d;
    logic               overflow_q, overflow_d;

    logic               accept;
    logic               capture;
    logic               pop;
    logic               credit_take;
    logic               credit_give;
    logic               fifo_full;
    logic               fifo_empty;

    // The bypass exists only so the full-FIFO drop path can be exercised deliberately.
    assign accept      = issue_valid && (issue_ready_q || CREDIT_CHECK_BYPASS);
    assign capture     = dly_q[LATENCY-1];
    assign pop         = out_valid && out_ready;
    assign credit_take = accept && (credits_q != '0);
    assign credit_give = pop && (credits_q != CNT_W'(DEPTH));

    always_comb begin
        dly_d = (dly_q << 1) | LATENCY'(accept);

        credits_d = credits_q;
        case ({credit_take, credit_give})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase

        issue_ready_d = (credits_d != '0);
        overflow_d    = overflow_q || (capture && fifo_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_q         <= '0;
            credits_q     <= CNT_W'(DEPTH);
            issue_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            dly_q         <= dly_d;
            credits_q     <= credits_d;
            issue_ready_q <= issue_ready_d;
            overflow_q    <= overflow_d;
        end
    end

    dsp_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (chain_result),
        .pop       (pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid    = !fifo_empty;
    assign issue_ready  = issue_ready_q;
    assign overflow_err = overflow_q;
    assign inflight     = CNT_W'(DEPTH) - credits_q;

endmodule

// File: tb/tb_dsp_chain_result_drain.sv
// Bench for dsp_chain_result_drain: table vectors, directed corner sequences and a
// queue-based reference model checked every cycle.
module tb_dsp_chain_result_drain;

    localparam int LAT = 4;
    localparam int DEP = 8;
    localparam int CW  = $clog2(DEP + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid, out_ready;
    logic [31:0]   chain_result;
    logic          issue_ready, out_valid, overflow_err;
    logic [31:0]   out_data;
    logic [CW-1:0] inflight;

    logic          iv2, ordy2;
    logic [31:0]   cr2;
    logic          rdy2, vld2, ovf2;
    logic [31:0]   data2;
    logic [CW-1:0] infl2;

    always #5 clk = ~clk;

    dsp_chain_result_drain #(.DATA_W(32), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .chain_result (chain_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .inflight     (inflight),
        .overflow_err (overflow_err)
    );

    dsp_chain_result_drain #(.DATA_W(32), .LATENCY(LAT), .DEPTH(DEP), .CREDIT_CHECK_BYPASS(1'b1)) dut_ovf (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (iv2),
        .issue_ready  (rdy2),
        .chain_result (cr2),
        .out_valid    (vld2),
        .out_ready    (ordy2),
        .out_data     (data2),
        .inflight     (infl2),
        .overflow_err (ovf2)
    );

    int          total = 0;
    int          bad   = 0;
    int          edge_no = 0;
    int          m_acc[$];
    logic [31:0] m_fifo[$];
    int          m_infl;
    bit          m_ready, m_ovf;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [31:0] cr;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_data;
        int          e_infl;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc.delete();
        m_fifo.delete();
        m_infl  = 0;
        m_ready = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_check();
        chk("m_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
        chk("m_data", out_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
        chk("m_inflight", 32'(inflight), 32'(m_infl));
        chk("m_ready", 32'(issue_ready), 32'(m_ready));
        chk("m_ovf", 32'(overflow_err), 32'(m_ovf));
    endtask

    function automatic bit cap_next();
        return (m_acc.size() != 0) && (m_acc[0] + LAT == edge_no);
    endfunction

    // One clock edge: the model decides from pre-edge inputs, then outputs are compared.
    task automatic tick();
        bit          acc, pop, cap, rst_s;
        int          pre;
        logic [31:0] cr_s;
        rst_s = reset;
        acc   = rst_s && issue_valid && m_ready;
        pop   = rst_s && (m_fifo.size() != 0) && out_ready;
        cap   = rst_s && cap_next();
        pre   = m_fifo.size();
        cr_s  = chain_result;
        @(posedge clk);
        if (rst_s) begin
            if (pop) void'(m_fifo.pop_front());
            if (cap) begin
                void'(m_acc.pop_front());
                if (pre >= DEP) m_ovf = 1'b1;
                else m_fifo.push_back(cr_s);
            end
            if (acc) begin
                m_acc.push_back(edge_no);
                m_infl++;
            end
            if (pop) m_infl--;
            m_ready = (m_infl < DEP);
        end
        edge_no++;
        #1;
        model_check();
    endtask

    initial begin
        int acc_cnt, words, pops, rdy_low;

        vecs[0] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         0};
        vecs[1] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1};
        vecs[2] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1};
        vecs[3] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1};
        vecs[4] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1};
        vecs[5] = '{1'b0, 1'b0, 32'h3F80_0000, 1'b1, 1'b1, 32'h3F80_0000, 1};
        vecs[6] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h3F80_0000, 1};
        vecs[7] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         0};
        vecs[8] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         0};

        issue_valid = 1'b0; out_ready = 1'b0; chain_result = '0;
        iv2 = 1'b0; ordy2 = 1'b0; cr2 = '0;
        model_reset();
        reset = 1'b1;
        #1 reset = 1'b0;

        // Held in reset across two edges with issue requested
        issue_valid = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(issue_ready), 32'h0);
        chk("rst_ovf2", 32'(ovf2), 32'h0);
        reset = 1'b1;

        // Release, first-edge ready, single issue with fall-through and pop
        for (int i = 0; i < 9; i++) begin
            issue_valid  = vecs[i].iv;
            out_ready    = vecs[i].ordy;
            chain_result = vecs[i].cr;
            tick();
            chk($sformatf("tbl%0d_ready", i), 32'(issue_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
            chk($sformatf("tbl%0d_data", i), out_data, vecs[i].e_data);
            chk($sformatf("tbl%0d_inflight", i), 32'(inflight), 32'(vecs[i].e_infl));
        end

        // Back-to-back issue with a stalled output: credits stop issue at DEPTH
        out_ready = 1'b0;
        issue_valid = 1'b1;
        acc_cnt = 0;
        words = 0;
        for (int i = 0; i < 12; i++) begin
            if (cap_next()) begin
                words++;
                chain_result = 32'(words);
            end else begin
                chain_result = $urandom;
            end
            if (issue_valid && issue_ready) acc_cnt++;
            tick();
        end
        chk("b2b_accepts", 32'(acc_cnt), 32'd8);
        chk("b2b_ready", 32'(issue_ready), 32'h0);
        chk("b2b_inflight", 32'(inflight), 32'd8);
        issue_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("b2b_valid%0d", k), 32'(out_valid), 32'h1);
            chk($sformatf("b2b_word%0d", k), out_data, 32'(k));
            tick();
        end
        chk("b2b_empty", 32'(out_valid), 32'h0);
        chk("b2b_ovf", 32'(overflow_err), 32'h0);
        chk("b2b_drained", 32'(inflight), 32'h0);

        // Steady state streaming
        issue_valid = 1'b1;
        out_ready = 1'b1;
        pops = 0;
        rdy_low = 0;
        for (int i = 0; i < 40; i++) begin
            chain_result = $urandom;
            if (out_valid && out_ready) pops++;
            if (!issue_ready) rdy_low++;
            tick();
        end
        chk("steady_pops", 32'(pops), 32'd35);
        chk("steady_ready_low", 32'(rdy_low), 32'd0);
        issue_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic: first half mostly stalled, second half mostly draining
        for (int i = 0; i < 300; i++) begin
            issue_valid  = 1'($urandom_range(0, 1));
            out_ready    = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            chain_result = $urandom;
            tick();
        end
        issue_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("rand_drained", 32'(inflight), 32'h0);

        // Reset with three results in the pipe and two buffered
        out_ready = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chain_result = 32'hC000_0000 + 32'(i);
            tick();
        end
        issue_valid = 1'b0;
        chain_result = 32'hC000_0005;
        tick();
        chk("mid_inflight", 32'(inflight), 32'd5);
        chk("mid_valid", 32'(out_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data", out_data, 32'h0);
        chk("mid_rst_ready", 32'(issue_ready), 32'h0);
        chk("mid_rst_inflight", 32'(inflight), 32'h0);
        model_reset();
        issue_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        issue_valid = 1'b0;
        out_ready = 1'b1;
        chain_result = $urandom;
        tick();
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        words = 0;
        for (int i = 0; i < 10; i++) begin
            chain_result = $urandom;
            if (out_valid && out_ready) words++;
            tick();
        end
        chk("post_rst_words", 32'(words), 32'd1);

        // Overflow: bypassed credit check pushes a ninth capture into a full FIFO
        out_ready = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            iv2 = (n <= 9);
            cr2 = 32'hA000_0000 + 32'(n);
            tick();
            if (n == 12) chk("ovf_before_drop", 32'(ovf2), 32'h0);
        end
        iv2 = 1'b0;
        chk("ovf_set", 32'(ovf2), 32'h1);
        chk("ovf_inflight", 32'(infl2), 32'd8);
        chk("ovf_ready", 32'(rdy2), 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("ovf_sticky", 32'(ovf2), 32'h1);
        ordy2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_valid%0d", k), 32'(vld2), 32'h1);
            chk($sformatf("ovf_word%0d", k), data2, 32'hA000_0005 + 32'(k));
            tick();
        end
        chk("ovf_empty", 32'(vld2), 32'h0);
        chk("ovf_still_set", 32'(ovf2), 32'h1);
        chk("ovf_credits_back", 32'(rdy2), 32'h1);
        reset = 1'b0;
        #1;
        chk("ovf_cleared", 32'(ovf2), 32'h0);
        model_reset();
        tick();
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
